// File: rtl/seg_scan_drv.sv
// seg_scan_drv: eight-digit multiplexed seven-segment driver with blink, minus and leading-zero suppression.
module seg_scan_drv #(
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_scan,
  input  logic                    clk_blink,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   minus_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);
  logic [SYNC_STAGES-1:0]  scan_sync, blink_sync;
  logic                    scan_d, tick, blink_s, first_load, load;
  logic [2:0]              idx;
  logic [4*NUM_DIGITS-1:0] f_digits;
  logic [NUM_DIGITS-1:0]   f_dp, f_blink, f_minus;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n, blank, zero_up;
  logic [3:0]              nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick    = scan_sync[SYNC_STAGES-1] & ~scan_d;
  assign blink_s = blink_sync[SYNC_STAGES-1];
  // The frame reloads at the end of every scan and once right after reset so the first frame is live.
  assign load    = tick & ((idx == 3'd7) | first_load);
  assign nib     = f_digits[{idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_sync  <= '0;
      blink_sync <= '0;
      scan_d     <= 1'b0;
      idx        <= '0;
      first_load <= 1'b1;
      f_digits   <= '0;
      f_dp       <= '0;
      f_blink    <= '0;
      f_minus    <= '0;
      an         <= '0;
      seg        <= '0;
      dp         <= 1'b0;
    end else begin
      scan_sync  <= {scan_sync[SYNC_STAGES-2:0], clk_scan};
      blink_sync <= {blink_sync[SYNC_STAGES-2:0], clk_blink};
      scan_d     <= scan_sync[SYNC_STAGES-1];
      if (tick) idx <= idx + 3'd1;
      if (load) begin
        first_load <= 1'b0;
        f_digits   <= digits;
        f_dp       <= dp_mask;
        f_blink    <= blink_mask;
        f_minus    <= minus_mask;
      end
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

  // A digit is a leading zero only if it and everything to its left is zero with no minus sign.
  always_comb begin
    zero_up = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (k >= int'(idx) && (f_digits[4*k +: 4] != 4'd0 || f_minus[k])) zero_up = 1'b0;
    blank = ~en | (f_blink[idx] & blink_s);
    an_n  = blank ? '0 : {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    seg_n = blank ? 7'h00 :
            f_minus[idx] ? 7'h40 :
            (lz_en && idx != 3'd0 && zero_up) ? 7'h00 : hex7(nib);
    dp_n  = ~blank & f_dp[idx];
  end
endmodule

// File: doc/seg_scan_drv.md
Name: seg_scan_drv

Overview:
Eight-digit multiplexed seven-segment driver for the calculator display; sits directly downstream of the clock divider. Consumes the divider's 1 kHz scan clock and 2 Hz blink clock as level signals, synchronising and edge-detecting them in the system clock domain. Decodes one hex digit per scan step and drives a registered anode, segment and decimal-point bus. Supports per-digit blink, minus sign and leading-zero suppression.

Parameters:
NUM_DIGITS, 8, digit count; fixed at 8, and the digit index is 3 bits.
SYNC_STAGES, 2, flip-flop synchroniser depth for clk_scan and clk_blink.

Ports:
clk  input  1  100 MHz system clock; the only clock in the block.
rst  input  1  synchronous, active-high reset.
clk_scan  input  1  1 kHz square wave from the divider; treated as data, never as a clock.
clk_blink  input  1  2 Hz square wave from the divider; treated as data.
en  input  1  display enable.
lz_en  input  1  leading-zero suppression enable.
digits  input  32  hex nibbles; digits[4i+3:4i] is digit i, and digit 0 is the rightmost.
dp_mask  input  8  decimal point per digit.
blink_mask  input  8  digits that blink.
minus_mask  input  8  digit shows '-' instead of its value.
an  output  8  digit select, active-high, one-hot or all zero.
seg  output  7  segments, active-high; seg[0]=a … seg[6]=g.
dp  output  1  decimal point, active-high.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; every register clears only on a rising clk edge with rst=1.
- Reset values: an=0, seg=0, dp=0, idx=0, synchroniser and edge registers 0, frame registers 0, first_load=1.
- Scan synchroniser:
  - clk_scan passes through SYNC_STAGES flops, then one delay flop.
  - tick = synced & ~delayed, a single-cycle pulse per clk_scan rising edge.
- Blink synchroniser: clk_blink passes through SYNC_STAGES flops to give blink_s, used as a level.
- Digit index: idx increments on tick and wraps from 7 to 0. No change without tick, so a stuck clk_scan freezes the display on one digit.
- Frame latch:
  - digits, dp_mask, blink_mask and minus_mask are copied to frame registers on a tick with idx==7, and on the first tick after reset (which then clears first_load).
  - Input changes mid-frame appear only from the next frame. en, lz_en and blink_s are not latched.
- Output register: an, seg and dp are registered every cycle from the current idx and the frame registers, so outputs lag idx by 1 cycle.
- Latency: an changes on the 4th clk edge after clk_scan goes high, counting the sampling edge as the 1st (with SYNC_STAGES=2).
- Decode priority, highest first, for digit i=idx:
  1. en=0: an=0, seg=0, dp=0. idx keeps advancing.
  2. blink_mask[i]=1 and blink_s=1: an=0, seg=0, dp=0, i.e. blanked during the high half-period of the blink clock.
  3. minus_mask[i]=1: seg=7'h40.
  4. lz_en=1, i≠0, and frame digits i..7 all zero, with no minus_mask bit set at any position ≥i: seg=0, an still asserted.
  5. Otherwise hex decode.
  - In cases 3–5, an=(1<<i) and dp=dp_mask[i].
- Hex decode, seg[6:0]:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- Boundary cases:
  - Digit 0 is never zero-suppressed.
  - A tick in the same cycle as rst=1 is ignored; reset wins.
  - Reset mid-frame restarts at idx=0 with cleared frame registers and reloads on the next tick.
  - Glitch-free: an is never multi-hot.

Test Plan:
- Reset with clk_scan toggling → an=0, seg=0, dp=0 while rst=1. After release, the first tick loads the frame; an=8'h02 then follows idx=1 at edge+4 (the first tick advances idx from 0 to 1 while loading).
- digits=32'h01234567, en=1, lz_en=0, 9 clk_scan rising edges → an cycles 01,02,…,80,01. seg=6F? No: digit0=7 gives 07, digit1=6 gives 7D, …, digit7=0 gives 3F.
- lz_en=1, digits=32'h00000305 → digits 7..3 show an active with seg=0; digit2 shows seg 4F; digit1 shows 3F (not suppressed, because a non-zero digit lies above it); digit0 shows 6D.
- blink_mask=8'h01, clk_blink high → an=0 whenever idx=0. With clk_blink low, digit 0 displays normally. Other digits are unaffected.
- minus_mask=8'h80, digits=0, lz_en=1 → digit7 seg=40 and digit0 seg=3F. dp_mask=8'h04 gives dp=1 only when an=8'h04.
- Change digits while idx=3 → outputs unchanged until idx wraps through 7→0. Assert rst while idx=5 → next cycle an=0 and idx=0.
